shift_div: RTL
==============

# shift_div

Sequential unsigned integer divider: the inverse operation of the lookup-table multiplier in the arithmetic library. It accepts a dividend/divisor pair on a start pulse, runs a restoring shift-subtract loop one quotient bit per clock, and presents quotient and remainder with a one-cycle done strobe. It sits beside the multiplier in the arithmetic datapath, with results held stable for downstream sampling.

## Interface
- WIDTH, 4, operand/result width in bits (legal 2..16)
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle strobe; quot/rem valid
- quot  out  WIDTH  quotient, held until next accepted start
- rem  out  WIDTH  remainder, held until next accepted start
- dz  out  1  divide-by-zero flag, valid with done, held with results

## Operation
- One clock, sys_clk; reset is synchronous and active-high on sys_rst.
- States: IDLE, CALC, DONE.
- IDLE: start=1 captures a into dividend shift register, b into divisor register, clears partial remainder (WIDTH+1 bits) and iteration counter, clears dz -> CALC. start=0 stays IDLE.
- CALC, per cycle: partial = {partial[WIDTH-1:0], dividend MSB}; dividend shifts left by 1; if partial >= {1'b0, divisor}: partial -= divisor, shift 1 into quotient LSB, else shift 0. Counter increments; after WIDTH iterations -> DONE.
- DONE: done=1 for exactly one cycle; quot and rem (partial[WIDTH-1:0]) registered -> IDLE.
- All arithmetic unsigned; partial remainder carries one guard bit so the compare never overflows.
- Divisor zero (natural algorithm): quot = all ones, rem = a, dz=0.
- start while busy (CALC or DONE): ignored, no queuing; operands may change freely.
- quot/rem/dz are not cleared on return to IDLE; they change only on the next DONE or on reset.

## Timing
- Reset (sys_rst=1 at an edge): state IDLE, busy=0, done=0, quot=0, rem=0, dz=0, internal registers 0. Reset mid-CALC aborts; no done is produced.
- start sampled at edge 0 -> busy=1 after edge 0; iterations at edges 1..WIDTH; done=1 after edge WIDTH+1; busy=0, done=0 after edge WIDTH+2.
- Latency start-to-done: WIDTH+1 cycles. Minimum issue interval: WIDTH+2 cycles; start may be asserted in the cycle done is high but is ignored; it is accepted in the following IDLE cycle.
- quot/rem/dz valid from the done cycle onward.

## Configuration
- SHIFT_DIV_DZ_CHECK_EN defined: in IDLE, start with b==0 skips CALC -> DONE directly; quot = all ones, rem = a, dz=1; latency 1 cycle (done after edge 1).
- Not defined: no zero check; b==0 runs the full loop with the natural result above; dz tied 0.
- Both builds yield identical quot/rem for every input; only latency and dz differ.

## Structure
- Package shift_div_pkg: state encoding (IDLE, CALC, DONE) and counter-width constant function (clog2 of WIDTH+1).
- Sub-module shift_div_step: combinational single restoring step (partial in, divisor, next dividend bit -> partial out, quotient bit); the top instantiates one copy, the FSM and registers live in shift_div.

## Test plan
- WIDTH=4, a=13, b=3, start 1 cycle -> done exactly 5 cycles later, quot=4, rem=1, dz=0, busy high 6 cycles.
- WIDTH=4, a=2, b=3 -> quot=0, rem=2; a=15, b=1 -> quot=15, rem=0.
- WIDTH=4, a=9, b=0 -> quot=15, rem=9; with SHIFT_DIV_DZ_CHECK_EN: done 1 cycle after start, dz=1; without: done after 5 cycles, dz=0.
- Start pulsed again with a=7, b=2 during CALC of 13/3 -> ignored, result 4/1; results held unchanged 10 cycles after done.
- sys_rst=1 for one edge at the 2nd CALC cycle -> busy=0, quot=rem=dz=0 next cycle, no done; a new start of 6/4 then yields quot=1, rem=2.
- WIDTH=8, a=255, b=16 -> quot=15, rem=15 after 9 cycles; exhaustive WIDTH=4 sweep of all 256 pairs matches a/b and a%b (b=0 per dz rule).

Source files
------------

// File: rtl/shift_div_pkg.sv
// shift_div_pkg: shared FSM state encoding and counter sizing for the
// shift_div restoring divider.
package shift_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_div_if.sv
// shift_div_if: request/result bundle of the shift_div divider.
// master = requester (drives start/a/b), slave = divider.
interface shift_div_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             dz;

    modport master (
        output start, a, b,
        input  busy, done, quot, rem, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, quot, rem, dz
    );
endinterface

// File: rtl/shift_div_step.sv
// shift_div_step: one combinational restoring division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits. The compare is done on WIDTH+1 bits (guard bit) so it
// never overflows; the result is always below the divisor and fits WIDTH bits.
module shift_div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] partial_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] partial_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // Shift-in, compare against the zero-extended divisor, conditionally subtract.
    always_comb begin
        shifted   = {partial_i, bit_i};
        partial_o = shifted[WIDTH-1:0];
        qbit_o    = 1'b0;
        if (shifted >= {1'b0, divisor_i}) begin
            partial_o = WIDTH'(shifted - {1'b0, divisor_i});
            qbit_o    = 1'b1;
        end
    end

endmodule

// File: rtl/shift_div.sv
// shift_div: sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: SHIFT_DIV_DZ_CHECK_EN (divide-by-zero short cut, dz flag).
module shift_div
    import shift_div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    shift_div_if.slave bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] quot_sr_q, quot_sr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SHIFT_DIV_DZ_CHECK_EN
    logic             dz_pend_q, dz_pend_d;
    logic             dz_q, dz_d;
`endif

    logic [WIDTH-1:0] step_partial;
    logic             step_qbit;

    shift_div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i (partial_q),
        .divisor_i (divisor_q),
        .bit_i     (dividend_q[WIDTH-1]),
        .partial_o (step_partial),
        .qbit_o    (step_qbit)
    );

    // Next-state and datapath update for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        partial_d  = partial_q;
        quot_sr_d  = quot_sr_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
`ifdef SHIFT_DIV_DZ_CHECK_EN
        dz_pend_d  = dz_pend_q;
        dz_d       = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dividend_d = bus.a;
                    divisor_d  = bus.b;
                    partial_d  = '0;
                    cnt_d      = '0;
                    quot_sr_d  = '0;
                    state_d    = CALC;
`ifdef SHIFT_DIV_DZ_CHECK_EN
                    // Zero divisor: preload the natural result and a full
                    // counter so CALC only spends its final cycle.
                    dz_pend_d = (bus.b == '0);
                    if (bus.b == '0) begin
                        cnt_d     = CW'(WIDTH);
                        quot_sr_d = '1;
                        partial_d = bus.a;
                    end
`endif
                end
            end
            CALC: begin
                if (cnt_q == CW'(WIDTH)) begin
                    quot_d  = quot_sr_q;
                    rem_d   = partial_q;
`ifdef SHIFT_DIV_DZ_CHECK_EN
                    dz_d    = dz_pend_q;
`endif
                    state_d = DONE;
                end else begin
                    partial_d  = step_partial;
                    quot_sr_d  = {quot_sr_q[WIDTH-2:0], step_qbit};
                    dividend_d = dividend_q << 1;
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            partial_q  <= '0;
            quot_sr_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
`ifdef SHIFT_DIV_DZ_CHECK_EN
            dz_pend_q  <= 1'b0;
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            partial_q  <= partial_d;
            quot_sr_q  <= quot_sr_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
`ifdef SHIFT_DIV_DZ_CHECK_EN
            dz_pend_q  <= dz_pend_d;
            dz_q       <= dz_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
`ifdef SHIFT_DIV_DZ_CHECK_EN
    assign bus.dz   = dz_q;
`else
    assign bus.dz   = 1'b0;
`endif

endmodule
